// File: rtl/lfsr_galois_gen_if.sv
// Output handshake bundle of the Galois LFSR generator: producer drives
// valid_out/q_out, consumer drives rdy_in.
interface lfsr_galois_gen_if #(
  parameter int WIDTH = 16
);
  logic             valid_out;
  logic             rdy_in;
  logic [WIDTH-1:0] q_out;

  modport master (output valid_out, output q_out, input rdy_in);
  modport slave  (input valid_out, input q_out, output rdy_in);
endinterface

// File: rtl/lfsr_galois_gen.sv
// Parametrised Galois LFSR source with reloadable taps/seed, zero-lock repair.
// Optional period monitor enabled by defining LFSR_PERIOD_EN.
module lfsr_galois_gen #(
  parameter int               WIDTH        = 16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(16'h8005)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic               seed_valid_in,
  input  logic [WIDTH-1:0]   taps_in,
  input  logic               taps_valid_in,
  lfsr_galois_gen_if.master  bus,
  output logic               lockup_out,
  output logic               wrap_out,
  output logic [WIDTH-1:0]   period_out,
  output logic               state_out
);

  // Handshake: a word is transferred on every rising edge where
  // valid_out && rdy_in; q_out is held stable while valid_out && !rdy_in.

  typedef enum logic {ST_SEED = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] taps_q;
  logic             lockup_q;
  logic             valid;
  logic             advance;
  logic [WIDTH-1:0] adv_raw;
  logic [WIDTH-1:0] adv_fix;
  logic [WIDTH-1:0] seed_fix;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] taps);
    return {cur[WIDTH-2:0], 1'b0} ^ (taps & {WIDTH{cur[WIDTH-1]}});
  endfunction

  // STEPS shifts are unrolled into one combinational cone.
  always_comb begin
    adv_raw = q_q;
    for (int s = 0; s < STEPS; s++) begin
      adv_raw = shift_once(adv_raw, taps_q);
    end
  end

  assign adv_fix  = (adv_raw == '0) ? WIDTH'(1) : adv_raw;
  assign seed_fix = (seed_in == '0) ? WIDTH'(1) : seed_in;
  assign advance  = valid && bus.rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_valid_in) begin
      state_d = ST_SEED;
    end else if (state_q == ST_SEED) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    valid = (state_q == ST_RUN);
  end

  // Reseed beats a same-cycle advance; tap loads never affect the current advance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q_q      <= seed_fix;
      lockup_q <= (seed_in == '0);
      taps_q   <= DEFAULT_TAPS | WIDTH'(1);
    end else begin
      if (taps_valid_in) begin
        taps_q <= taps_in | WIDTH'(1);
      end
      if (seed_valid_in) begin
        q_q      <= seed_fix;
        lockup_q <= (seed_in == '0);
      end else if (advance) begin
        q_q      <= adv_fix;
        lockup_q <= (adv_raw == '0);
      end else begin
        lockup_q <= 1'b0;
      end
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seed_q   <= seed_fix;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      period_q <= '0;
    end else if (seed_valid_in) begin
      seed_q <= seed_fix;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (advance) begin
      if (adv_fix == seed_q) begin
        wrap_q   <= 1'b1;
        period_q <= cnt_q + WIDTH'(1);
        cnt_q    <= '0;
      end else begin
        wrap_q <= 1'b0;
        cnt_q  <= cnt_q + WIDTH'(1);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap_out   = wrap_q;
  assign period_out = period_q;
`else
  assign wrap_out   = 1'b0;
  assign period_out = '0;
`endif

  assign bus.valid_out = valid;
  assign bus.q_out     = q_q;
  assign lockup_out    = lockup_q;
  assign state_out     = state_q;

endmodule

// File: doc/lfsr_galois_gen.md
# lfsr_galois_gen

Parametrised Galois-form LFSR pseudo-random source, the generalised successor to the fixed 16-bit generator. Width, tap polynomial and bits-per-advance are configurable. The tap polynomial and seed are reloadable at run time. Output is delivered through a valid/ready handshake, all-zero lock-up is repaired automatically, and an optional period monitor is available. It feeds dither/noise consumers in the camera pipeline.

## Interface
- WIDTH, 16, state/output width (4..32)
- STEPS, 1, LFSR shifts applied per accepted output (1..WIDTH)
- DEFAULT_TAPS, 16'h8005 (WIDTH bits), tap mask loaded at reset

Ports, as name, direction, width, meaning:
- clk_in, input, 1, sole clock
- rst_in, input, 1, reset; synchronous, active-high
- seed_in, input, WIDTH, seed value; sampled at reset and on seed_valid_in
- seed_valid_in, input, 1, runtime reseed strobe
- taps_in, input, WIDTH, new tap mask
- taps_valid_in, input, 1, tap mask load strobe
- rdy_in, input, 1, consumer ready
- valid_out, output, 1, q_out holds a valid word
- q_out, output, WIDTH, current LFSR state
- lockup_out, output, 1, one-cycle pulse when an all-zero state was replaced by 1
- wrap_out, output, 1, one-cycle pulse when the state returns to the last seed
- period_out, output, WIDTH, advance count of the last completed period

## Operation
- Shift rule, applied once per shift: next[i] = (i==0 ? 0 : q[i-1]) ^ (taps[i] & q[WIDTH-1]).
  - With taps 0x8005, bits 0, 2 and 15 receive the feedback.
- Advance: valid_out && rdy_in. q_out takes the result of STEPS chained shifts in one cycle.
- Advance uses combinational unrolling only; there is no multi-cycle iteration.
- Tap register:
  - Loaded from DEFAULT_TAPS on reset and from taps_in on taps_valid_in.
  - Bit 0 is always forced to 1.
- FSM states: SEED and RUN.
  - SEED: valid_out=0. It lasts exactly one cycle, then the FSM moves to RUN.
  - RUN: valid_out=1. Advances on handshake.
  - seed_valid_in in any state loads the seed and moves the FSM to SEED.
- Zero repair:
  - A seed of 0 is loaded as 1 and lockup_out pulses.
  - Any advance result of 0 is also replaced by 1 with a lockup_out pulse; this is possible only with degenerate taps.
- Priority: rst_in > seed_valid_in > advance.
  - taps_valid_in is independent of this priority. An advance in the same cycle uses the old taps; the new taps apply from the next advance.
- Seed and advance in the same cycle: the handshake counts as completed, but the advance result is discarded and the seed wins.
- Period monitor (macro-dependent):
  - A WIDTH-bit counter is cleared on seed load and incremented per advance.
  - When an advance result equals the stored seed, wrap_out pulses, period_out latches count+1, and the counter clears.
  - The counter wraps modulo 2^WIDTH.

## Timing
- Reset edge: q_out=seed (zero-repaired), state=SEED, valid_out=0, wrap_out=0, period_out=0, taps=DEFAULT_TAPS|1.
  - lockup_out=1 on the reset edge only if seed_in=0; otherwise 0.
- First edge after reset or reseed: valid_out=1.
- Handshake latency: the new q_out is visible on the edge after the accepting cycle. Full throughput of 1 word/cycle is sustained while rdy_in=1.
- valid_out=1 && rdy_in=0: q_out is held bit-stable.
- lockup_out and wrap_out are registered and coincide with the edge on which q_out shows the repaired or wrapped value.
- Reset mid-stream overrides everything. Any pending handshake is lost.

## Configuration
- LFSR_PERIOD_EN defined: the period counter, stored seed, wrap_out and period_out are implemented as described.
- LFSR_PERIOD_EN undefined: that logic is removed and the wrap_out and period_out ports are tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=16, taps 0x8005, STEPS=1, seed 0x8000; one advance -> q_out=0x8005.
- Same setup but STEPS=2; one advance from seed 0x8000 -> q_out=0x800F.
- Seed 0x0000 via reset -> q_out=0x0001, lockup_out high for exactly 1 cycle, valid_out=1 one cycle later.
- valid_out=1, rdy_in=0 for 5 cycles -> q_out is constant.
  - Then seed_valid_in with seed 0x1234 and rdy_in=1 in the same cycle -> q_out=0x1234 and valid_out=0 for one cycle.
- WIDTH=4, taps 0x9, seed 0x1, rdy_in=1, LFSR_PERIOD_EN defined -> wrap_out pulses after 15 advances with period_out=15.
  - Undefined -> wrap_out=0 and period_out=0 throughout.
- taps_valid_in with taps_in=0x0 asserted together with an advance -> that advance uses the old taps; later advances use mask 0x0001.
